pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 3-stage F->D->W core: load-use interlock,
// branch/trap flushes, and the data-memory request wait machine with timeout watchdog.
module pipeline_hazard_ctrl #(
   parameter int DW      = 32,
   parameter int RW      = 5,
   parameter int TIMEOUT = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [RW-1:0] rs1_d_i,
   input  logic [RW-1:0] rs2_d_i,
   input  logic          rs1_used_d_i,
   input  logic          rs2_used_d_i,
   input  logic [RW-1:0] rd_w_i,
   input  logic          load_w_i,
   input  logic          mem_op_d_i,
   input  logic          dmem_ack_i,
   output logic          dmem_req_o,
   input  logic          branch_taken_d_i,
   input  logic          trap_i,
   input  logic          imem_valid_i,
   output logic          stall_f_o,
   output logic          stall_d_o,
   output logic          flush_d_o,
   output logic          flush_w_o,
   output logic          bus_err_o,
   output logic [DW-1:0] stall_cnt_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [0:0] ST_RUN       = 1'b0;
   localparam logic [0:0] ST_DMEM_WAIT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic          bus_err_q, bus_err_d;
   logic [DW-1:0] stall_cnt_q, stall_cnt_d;

   logic lu, timeout;
   logic sf, sd, fd, fw, req;

   assign lu = load_w_i && (rd_w_i != '0) &&
               ((rs1_used_d_i && (rs1_d_i == rd_w_i)) ||
                (rs2_used_d_i && (rs2_d_i == rd_w_i)));
   assign timeout = (wcnt_q == CW'(TIMEOUT));

   always_comb begin
      sf        = 1'b0;
      sd        = 1'b0;
      fd        = 1'b0;
      fw        = 1'b0;
      req       = 1'b0;
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      bus_err_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (trap_i) begin
               fd = 1'b1;
               fw = 1'b1;
            end else if (lu) begin
               sf = 1'b1;
               sd = 1'b1;
               fw = 1'b1;
            end else if (mem_op_d_i) begin
               req = 1'b1;
               if (dmem_ack_i) begin
                  fd = branch_taken_d_i || !imem_valid_i;
                  sf = !branch_taken_d_i && !imem_valid_i;
               end else begin
                  sf      = 1'b1;
                  sd      = 1'b1;
                  fw      = 1'b1;
                  state_d = ST_DMEM_WAIT;
                  wcnt_d  = CW'(1);
               end
            end else begin
               // D advances: a taken branch redirects the PC, otherwise an
               // empty fetch becomes a bubble in D while the PC holds.
               fd = branch_taken_d_i || !imem_valid_i;
               sf = !branch_taken_d_i && !imem_valid_i;
            end
         end
         ST_DMEM_WAIT: begin
            if (trap_i) begin
               fd      = 1'b1;
               fw      = 1'b1;
               state_d = ST_RUN;
               wcnt_d  = '0;
            end else if (dmem_ack_i || timeout) begin
               req       = dmem_ack_i;
               bus_err_d = !dmem_ack_i;
               fd        = branch_taken_d_i || !imem_valid_i;
               sf        = !branch_taken_d_i && !imem_valid_i;
               state_d   = ST_RUN;
               wcnt_d    = '0;
            end else begin
               req    = 1'b1;
               sf     = 1'b1;
               sd     = 1'b1;
               fw     = 1'b1;
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            wcnt_d  = '0;
         end
      endcase
      stall_cnt_d = (sd && (stall_cnt_q != '1)) ? stall_cnt_q + DW'(1) : stall_cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         wcnt_q      <= '0;
         bus_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         bus_err_q   <= bus_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Combinational controls are gated by reset so a request dies the instant reset asserts.
   assign stall_f_o   = sf  && rst_ni;
   assign stall_d_o   = sd  && rst_ni;
   assign flush_d_o   = fd  && rst_ni;
   assign flush_w_o   = fw  && rst_ni;
   assign dmem_req_o  = req && rst_ni;
   assign bus_err_o   = bus_err_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
